// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped, write-through data cache.
package dcache_pkg;

  localparam int DATA_W         = 32;
  localparam int SETS_DEF       = 16;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_REFILL,
    S_DONE
  } state_t;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag is whatever remains above the byte offset, word select and index.
  function automatic int tag_bits(input int sets, input int line_words);
    return DATA_W - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] wdata,
    input logic [3:0]        wstrb
  );
    logic [DATA_W-1:0] merged;
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage with a combinational hit compare; all ports address the
// line selected by the current core request.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  localparam int WW = word_bits(LINE_WORDS),
  localparam int IW = index_bits(SETS),
  localparam int TW = tag_bits(SETS, LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     rd_index,
  input  logic [WW-1:0]     rd_word,
  input  logic [TW-1:0]     rd_tag,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [WW-1:0]     fill_word,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval_en,
  input  logic              commit_en
);

  logic [SETS-1:0]   valid_q;
  logic [TW-1:0]     tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

  assign hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data = data_q[rd_index][rd_word];

  // NOTE: tag and data need no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[rd_index][rd_word] <= wr_data;
    end else if (fill_en) begin
      data_q[rd_index][fill_word] <= fill_data;
    end
    if (commit_en) begin
      tag_q[rd_index] <= rd_tag;
    end
  end

  // A line becomes valid only once its last beat lands, so an aborted refill leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (commit_en) begin
      valid_q[rd_index] <= 1'b1;
    end else if (inval_en) begin
      valid_q[rd_index] <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate D-cache controller answering the MEM stage
// and refilling lines from memory over a req/ack + rvalid burst interface.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [DATA_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [3:0]        core_wstrb,
  input  logic              Istall,
  output logic [DATA_W-1:0] Dcache_out,
  output logic              Dstall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WW = word_bits(LINE_WORDS);
  localparam int IW = index_bits(SETS);
  localparam int TW = tag_bits(SETS, LINE_WORDS);
  localparam logic [WW-1:0] LAST_BEAT = WW'(LINE_WORDS - 1);

  logic [WW-1:0]     word_sel;
  logic [IW-1:0]     index_sel;
  logic [TW-1:0]     tag_sel;
  logic [DATA_W-1:0] line_base;
  logic              unused_addr_bits;

  assign word_sel         = core_addr[WW+1:2];
  assign index_sel        = core_addr[IW+WW+1:WW+2];
  assign tag_sel          = core_addr[DATA_W-1:IW+WW+2];
  assign line_base        = {core_addr[DATA_W-1:WW+2], {(WW+2){1'b0}}};
  assign unused_addr_bits = ^core_addr[1:0];

  state_t            state_q, state_d;
  logic [WW-1:0]     beat_q;
  logic [DATA_W-1:0] out_q;
  logic              hit;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, fill_en, inval_en, commit_en;

  dcache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (index_sel),
    .rd_word   (word_sel),
    .rd_tag    (tag_sel),
    .hit       (hit),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_data   (merge_bytes(rd_data, core_wdata, core_wstrb)),
    .fill_en   (fill_en),
    .fill_word (beat_q),
    .fill_data (mem_rdata),
    .inval_en  (inval_en),
    .commit_en (commit_en)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    Dstall     = 1'b0;
    Dcache_out = '0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    inval_en   = 1'b0;
    commit_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        Dstall = core_req && (core_we || !hit);
        if (core_req && core_we) begin
          state_d = S_WRITE;
          wr_en   = hit;
        end else if (core_req && !hit) begin
          state_d  = S_REFILL;
          inval_en = 1'b1;
        end else if (core_req) begin
          Dcache_out = rd_data;
        end
      end
      S_WRITE: begin
        Dstall = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_REFILL: begin
        Dstall = 1'b1;
        if (mem_rvalid) begin
          fill_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            commit_en = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        Dcache_out = out_q;
        if (!Istall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      out_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_WRITE) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
            mem_wstrb <= core_wstrb;
            out_q     <= '0;
          end else if (state_d == S_REFILL) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= line_base;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            beat_q    <= '0;
            out_q     <= '0;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
        end
        S_REFILL: begin
          if (mem_ack && mem_req) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
          end
          if (mem_rvalid) begin
            beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + WW'(1);
            // Capture the requested word as it streams past; it is held through DONE.
            if (beat_q == word_sel) out_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller, and the responder at the far end of the MEM-stage interface. It answers the pipeline's load/store requests and produces the Dstall and Dcache_out values that the MEM/WB pipeline register consumes. On a load miss it refills a line from memory over a req/ack + rvalid burst interface. Stores are always forwarded to memory.

Parameters:
SETS, 16, number of cache lines (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
core_req  in  1  MEM stage holds a load/store
core_we  in  1  1 = store, 0 = load
core_addr  in  `data_size  byte address, word aligned
core_wdata  in  `data_size  store data
core_wstrb  in  4  store byte enables
Istall  in  1  I-side stall; the pipeline is frozen while high
Dcache_out  out  `data_size  load data to the MEM/WB register
Dstall  out  1  hold pipeline; request not yet complete
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write request
mem_addr  out  `data_size  word address (line-aligned for refill)
mem_wdata  out  `data_size  write data
mem_wstrb  out  4  write byte enables
mem_ack  in  1  request accepted (write complete, or refill started)
mem_rvalid  in  1  refill beat valid
mem_rdata  in  `data_size  refill beat data

Behaviour:
- Address split: [1:0] ignored; word = [W+1:2] with W = log2 LINE_WORDS; index = next log2 SETS bits; tag = the remaining upper bits.
- Storage: valid[SETS], tag[SETS], data[SETS][LINE_WORDS], all in flops.
- Reset: every valid bit cleared, state IDLE. Outputs at reset: Dstall=0, Dcache_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. Reset asserted mid-refill or mid-write aborts the transaction; no partial line is left valid.
- hit = valid[index] && tag match (combinational).
- Dstall (combinational): in IDLE, Dstall = core_req && (core_we || !hit). In WRITE and REFILL, Dstall = 1. In DONE, Dstall = 0.
- FSM states: IDLE, WRITE, REFILL, DONE.
  - IDLE, read hit: Dcache_out = the addressed word, same cycle, zero extra latency; stay in IDLE.
  - IDLE, read miss: go to REFILL. Drive mem_req=1, mem_we=0, mem_addr = line base.
  - IDLE, store (hit or miss): go to WRITE. Drive mem_req=1, mem_we=1, mem_addr, mem_wdata and mem_wstrb from the core. On a store hit, merge the enabled bytes into the cached word in the same cycle the request is issued. On a store miss, the cache is unchanged.
  - WRITE: hold all mem_* outputs stable until mem_ack. On ack, drop mem_req and go to DONE.
  - REFILL: drop mem_req the cycle after mem_ack. Beats arrive in word order 0..LINE_WORDS-1 on mem_rvalid, which may arrive with gaps. Write each beat into data[index][beat] using a beat counter. After the last beat, set valid and tag and go to DONE. Dcache_out in DONE = the requested word.
  - DONE: Dcache_out is registered and held. Stay in DONE while Istall=1. Go to IDLE when Istall=0; this is the cycle the MEM/WB register captures the data.
- Core request fields must stay stable while Dstall=1; the controller samples them directly, not through a latch.
- Load data in IDLE is combinational. Dcache_out is 0 when core_req=0.
- mem_rvalid outside REFILL is ignored. mem_ack outside WRITE or REFILL with mem_req=1 is ignored.
- Beat counter wraps to 0 on line completion.

Decomposition:
- Add a dcache_pkg holding the FSM state enum, the address field-width localparams derived from SETS and LINE_WORDS, and the byte-merge function (word, wdata, wstrb) -> word.
- The storage array plus hit compare is natural as one sub-module, dcache_array: tag/valid/data flops with read, byte-write and beat-fill ports. The FSM stays in dcache_ctrl.

Test Plan:
- Load 0x0000_0040 after reset -> Dstall=1; mem_req, mem_addr=0x40. Memory acks, returns 0x11,0x22,0x33,0x44 -> DONE, Dcache_out=0x11, Dstall=0. Repeat the load -> hit, Dstall=0, no mem_req.
- Load 0x48 after that refill -> hit, Dcache_out=0x33 combinationally. Load 0x448 (same index, different tag) -> miss and refill, with the old line replaced.
- Store 0xAABBCCDD, wstrb=0011, to 0x44 (hit) -> cached word 0x0000CCDD, since the prior value was 0x22 with upper bytes 0. mem_we=1 is held until mem_ack with a 3-cycle delay; then DONE and Dstall=0.
- Store to an uncached address 0x800 -> memory write issued; a subsequent load of 0x800 misses (confirms no allocate).
- Refill with mem_rvalid gaps (beats on cycles 1,4,5,9) and Istall=1 for 3 cycles in DONE -> data correct; Dstall=0 and Dcache_out held throughout the Istall window.
- Assert rst during the REFILL beat 2 -> mem_req=0, state IDLE; a reload of the same address misses again.
